// File: rtl/clock_set_ctrl_if.sv
// Bundle between the button/counter front-end and the time-setting controller.
// The master side drives buttons, tick and live time; the slave side is the controller.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hour_10;
  logic [3:0] cur_hour1;
  logic [3:0] cur_min_10;
  logic [3:0] cur_min1;
  logic [3:0] cur_sec_10;
  logic [3:0] cur_sec1;
  logic       run_en;
  logic       load;
  logic [3:0] set_hour_10;
  logic [3:0] set_hour1;
  logic [3:0] set_min_10;
  logic [3:0] set_min1;
  logic [3:0] set_sec_10;
  logic [3:0] set_sec1;
  logic [1:0] edit_sel;
  logic       blink;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    output cur_hour_10, cur_hour1, cur_min_10, cur_min1, cur_sec_10, cur_sec1,
    input  run_en, load, edit_sel, blink,
    input  set_hour_10, set_hour1, set_min_10, set_min1, set_sec_10, set_sec1
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    input  cur_hour_10, cur_hour1, cur_min_10, cur_min1, cur_sec_10, cur_sec1,
    output run_en, load, edit_sel, blink,
    output set_hour_10, set_hour1, set_min_10, set_min1, set_sec_10, set_sec1
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the hh:mm:ss counters, edits a shadow copy field
// by field, then issues a one-cycle parallel load (or aborts after inactivity).
module clock_set_ctrl #(
  parameter int TIMEOUT_S = 30,
  parameter int TO_W      = 6
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave bus
);

  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  state_t          state_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            run_en_reg;
  logic            load_reg;
  logic            blink_reg;
  logic [1:0]      edit_sel_reg;
  logic [3:0]      set_hour_10_reg, set_hour1_reg;
  logic [3:0]      set_min_10_reg, set_min1_reg;
  logic [3:0]      set_sec_10_reg, set_sec1_reg;

  // Two-digit BCD increment that wraps to 00 after max_tens:max_ones.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                         input logic [3:0] max_tens, input logic [3:0] max_ones);
    if (tens == max_tens && ones == max_ones) return 8'h00;
    else if (ones == 4'd9)                    return {tens + 4'd1, 4'd0};
    else                                      return {tens, ones + 4'd1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= RUN;
      to_cnt_reg      <= '0;
      run_en_reg      <= 1'b1;
      load_reg        <= 1'b0;
      blink_reg       <= 1'b0;
      edit_sel_reg    <= 2'b00;
      set_hour_10_reg <= '0;
      set_hour1_reg   <= '0;
      set_min_10_reg  <= '0;
      set_min1_reg    <= '0;
      set_sec_10_reg  <= '0;
      set_sec1_reg    <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          load_reg  <= 1'b0;
          blink_reg <= 1'b0;
          if (bus.btn_mode) begin
            set_hour_10_reg <= bus.cur_hour_10;
            set_hour1_reg   <= bus.cur_hour1;
            set_min_10_reg  <= bus.cur_min_10;
            set_min1_reg    <= bus.cur_min1;
            set_sec_10_reg  <= bus.cur_sec_10;
            set_sec1_reg    <= bus.cur_sec1;
            state_reg       <= SET_H;
            run_en_reg      <= 1'b0;
            edit_sel_reg    <= 2'b01;
            to_cnt_reg      <= '0;
          end
        end
        SET_H, SET_M, SET_S: begin
          // Mode takes priority so a coincident inc never touches the field being left.
          if (bus.btn_mode) begin
            to_cnt_reg <= '0;
            if (state_reg == SET_H) begin
              state_reg    <= SET_M;
              edit_sel_reg <= 2'b10;
            end else if (state_reg == SET_M) begin
              state_reg    <= SET_S;
              edit_sel_reg <= 2'b11;
            end else begin
              state_reg    <= COMMIT;
              edit_sel_reg <= 2'b00;
              load_reg     <= 1'b1;
              blink_reg    <= 1'b0;
            end
          end else if (bus.btn_inc) begin
            to_cnt_reg <= '0;
            blink_reg  <= 1'b0;
            if (state_reg == SET_H)
              {set_hour_10_reg, set_hour1_reg} <= bcd_inc(set_hour_10_reg, set_hour1_reg, 4'd2, 4'd3);
            else if (state_reg == SET_M)
              {set_min_10_reg, set_min1_reg} <= bcd_inc(set_min_10_reg, set_min1_reg, 4'd5, 4'd9);
            else
              {set_sec_10_reg, set_sec1_reg} <= bcd_inc(set_sec_10_reg, set_sec1_reg, 4'd5, 4'd9);
          end else if (bus.tick_1hz) begin
            if (to_cnt_reg == TO_LAST) begin
              state_reg    <= RUN;
              run_en_reg   <= 1'b1;
              edit_sel_reg <= 2'b00;
              blink_reg    <= 1'b0;
              to_cnt_reg   <= '0;
            end else begin
              to_cnt_reg <= to_cnt_reg + 1'b1;
              blink_reg  <= ~blink_reg;
            end
          end
        end
        COMMIT: begin
          state_reg  <= RUN;
          load_reg   <= 1'b0;
          run_en_reg <= 1'b1;
        end
        default: begin
          state_reg    <= RUN;
          load_reg     <= 1'b0;
          run_en_reg   <= 1'b1;
          blink_reg    <= 1'b0;
          edit_sel_reg <= 2'b00;
          to_cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.run_en      = run_en_reg;
  assign bus.load        = load_reg;
  assign bus.blink       = blink_reg;
  assign bus.edit_sel    = edit_sel_reg;
  assign bus.set_hour_10 = set_hour_10_reg;
  assign bus.set_hour1   = set_hour1_reg;
  assign bus.set_min_10  = set_min_10_reg;
  assign bus.set_min1    = set_min1_reg;
  assign bus.set_sec_10  = set_sec_10_reg;
  assign bus.set_sec1    = set_sec1_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table, hand-written corner sequences and random
// stimulus checked against a field/second-level behavioural model.
module tb_clock_set_ctrl;
  localparam int TIMEOUT_S = 30;

  logic clk;
  logic rst;
  clock_set_ctrl_if bus();

  clock_set_ctrl #(.TIMEOUT_S(TIMEOUT_S), .TO_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0=run, 1..3=editing hour/min/sec, 4=commit cycle.
  int m_mode, m_h, m_m, m_s, m_cnt, m_blink;

  typedef struct packed {
    logic        mode;
    logic        inc;
    logic        tick;
    logic        run_en;
    logic        load;
    logic [1:0]  sel;
    logic        blink;
    logic [23:0] set;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bcd24(input int h, input int m, input int s);
    return 32'((h / 10) * 1048576 + (h % 10) * 65536 + (m / 10) * 4096 +
               (m % 10) * 256 + (s / 10) * 16 + (s % 10));
  endfunction

  function automatic logic [31:0] dut_set();
    return {8'h00, bus.set_hour_10, bus.set_hour1, bus.set_min_10, bus.set_min1,
            bus.set_sec_10, bus.set_sec1};
  endfunction

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hour_10 = 4'(h / 10);
    bus.cur_hour1   = 4'(h % 10);
    bus.cur_min_10  = 4'(m / 10);
    bus.cur_min1    = 4'(m % 10);
    bus.cur_sec_10  = 4'(s / 10);
    bus.cur_sec1    = 4'(s % 10);
  endtask

  task automatic model_reset();
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_blink = 0;
  endtask

  task automatic model_update(input logic md, input logic inc, input logic tk);
    if (m_mode == 0) begin
      if (md) begin
        m_h = int'(bus.cur_hour_10) * 10 + int'(bus.cur_hour1);
        m_m = int'(bus.cur_min_10) * 10 + int'(bus.cur_min1);
        m_s = int'(bus.cur_sec_10) * 10 + int'(bus.cur_sec1);
        m_mode = 1; m_cnt = 0; m_blink = 0;
      end
    end else if (m_mode <= 3) begin
      if (md) begin
        m_cnt = 0;
        m_mode = m_mode + 1;
        if (m_mode == 4) m_blink = 0;
      end else if (inc) begin
        m_cnt = 0; m_blink = 0;
        if (m_mode == 1)      m_h = (m_h + 1) % 24;
        else if (m_mode == 2) m_m = (m_m + 1) % 60;
        else                  m_s = (m_s + 1) % 60;
      end else if (tk) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == TIMEOUT_S) begin
          m_mode = 0; m_cnt = 0; m_blink = 0;
        end else begin
          m_blink = 1 - m_blink;
        end
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic check_model();
    check("run_en", 32'(bus.run_en), 32'(m_mode == 0));
    check("load", 32'(bus.load), 32'(m_mode == 4));
    check("edit_sel", 32'(bus.edit_sel), (m_mode >= 1 && m_mode <= 3) ? 32'(m_mode) : 32'd0);
    check("blink", 32'(bus.blink), 32'(m_blink));
    check("set", dut_set(), bcd24(m_h, m_m, m_s));
  endtask

  // One clock: inputs held across the edge, outputs sampled 1 time unit later.
  task automatic step(input logic md, input logic inc, input logic tk);
    bus.btn_mode = md;
    bus.btn_inc  = inc;
    bus.tick_1hz = tk;
    @(posedge clk);
    model_update(md, inc, tk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.tick_1hz = 1'b0;
    check_model();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 24'h095859};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 24'h105859};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 24'h105859};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 24'h105859};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 24'h105959};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 24'h100059};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 24'h100059};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 24'h100000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h100000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h100000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h100000};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 24'h100000};

    rst = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.tick_1hz = 1'b0;
    set_cur(12, 34, 56);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset: 100 ticks, no buttons.
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 1'b1);
    check("idle_sel", 32'(bus.edit_sel), 32'd0);
    check("idle_run", 32'(bus.run_en), 32'd1);
    $display("idle: 100 ticks after reset, run_en=%0b load=%0b", bus.run_en, bus.load);

    // Capture at 23:59:58 and hour wrap.
    set_cur(23, 59, 58);
    step(1'b1, 1'b0, 1'b0);
    check("capture_set", dut_set(), 32'h235958);
    check("capture_run_en", 32'(bus.run_en), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("hour_wrap", dut_set(), 32'h005958);
    $display("capture: set=%06h after hour increment", dut_set());
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Full session from 09:58:59 via the vector table.
    set_cur(9, 58, 59);
    for (int k = 0; k < 12; k++) begin
      step(vecs[k].mode, vecs[k].inc, vecs[k].tick);
      check("vec_run_en", 32'(bus.run_en), 32'(vecs[k].run_en));
      check("vec_load", 32'(bus.load), 32'(vecs[k].load));
      check("vec_sel", 32'(bus.edit_sel), 32'(vecs[k].sel));
      check("vec_blink", 32'(bus.blink), 32'(vecs[k].blink));
      check("vec_set", dut_set(), 32'(vecs[k].set));
      $display("vec %0d: mode=%0b inc=%0b tick=%0b -> run_en=%0b load=%0b sel=%0d set=%06h",
               k, vecs[k].mode, vecs[k].inc, vecs[k].tick, bus.run_en, bus.load,
               bus.edit_sel, dut_set());
    end

    // Inactivity timeout with an inc after tick 20.
    set_cur(7, 7, 7);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TIMEOUT_S - 1; k++) step(1'b0, 1'b0, 1'b1);
    check("timeout_pending", 32'(bus.edit_sel), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("timeout_run_en", 32'(bus.run_en), 32'd1);
    check("timeout_load", 32'(bus.load), 32'd0);
    check("timeout_sel", 32'(bus.edit_sel), 32'd0);
    check("timeout_set", dut_set(), 32'h080707);
    $display("timeout: run_en=%0b load=%0b set=%06h", bus.run_en, bus.load, dut_set());

    // Coincident mode+inc in SET_M.
    set_cur(12, 30, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("mode_wins_sel", 32'(bus.edit_sel), 32'd3);
    check("mode_wins_set", dut_set(), 32'h123000);
    $display("mode+inc: sel=%0d set=%06h", bus.edit_sel, dut_set());
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in SET_M after 5 incs.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
    check("pre_reset_set", dut_set(), 32'h123500);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_run_en", 32'(bus.run_en), 32'd1);
    check("async_sel", 32'(bus.edit_sel), 32'd0);
    check("async_set", dut_set(), 32'h0);
    check_model();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    $display("async reset: run_en=%0b load=%0b set=%06h", bus.run_en, bus.load, dut_set());

    // Random: busy buttons, then sparse buttons so timeouts occur.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0)
        set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    $display("random busy phase: %0d compared so far", n_cmp);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 31) == 0)
        set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 0);
    end
    $display("random sparse phase: %0d compared so far", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
